// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
// Purpose : Shared types and default parameters for the multiport register
//           file and its clear sequencer.
// Contents: clear_state_e (IDLE / CLEAR) and the default sizing constants.
// -----------------------------------------------------------------------------
package register_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_e;

    localparam int DEFAULT_DATA_WIDTH           = 8;
    localparam int DEFAULT_NUMBER_OF_REGISTERS  = 256;
    localparam int DEFAULT_NUMBER_OF_READ_PORTS = 2;

endpackage

// File: rtl/multiport_register_file_if.sv
// -----------------------------------------------------------------------------
// multiport_register_file_if
// Purpose : Bundles the write, read and clear signals of the register file.
//           Signal names carry the direction as seen by the register file.
// Modports: slave  - the register file itself
//           master - whatever drives the register file (CPU, testbench)
// Signals : write_valid_in / write_ready_out / write_register_address_in /
//           write_data_in, read_valid_in / read_register_address_in (packed,
//           port p at [p*ADDR_WIDTH +: ADDR_WIDTH]) / read_data_out (packed,
//           port p at [p*DATA_WIDTH +: DATA_WIDTH]) / read_valid_out,
//           clear_start_in / busy_out.
// -----------------------------------------------------------------------------
interface multiport_register_file_if
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH           = DEFAULT_DATA_WIDTH,
    parameter int NUMBER_OF_REGISTERS  = DEFAULT_NUMBER_OF_REGISTERS,
    parameter int NUMBER_OF_READ_PORTS = DEFAULT_NUMBER_OF_READ_PORTS
);
    localparam int ADDR_WIDTH = $clog2(NUMBER_OF_REGISTERS);

    logic                                       write_valid_in;
    logic                                       write_ready_out;
    logic [ADDR_WIDTH-1:0]                      write_register_address_in;
    logic [DATA_WIDTH-1:0]                      write_data_in;

    logic                                       read_valid_in;
    logic [NUMBER_OF_READ_PORTS*ADDR_WIDTH-1:0] read_register_address_in;
    logic [NUMBER_OF_READ_PORTS*DATA_WIDTH-1:0] read_data_out;
    logic                                       read_valid_out;

    logic                                       clear_start_in;
    logic                                       busy_out;

    modport slave (
        input  write_valid_in,
        output write_ready_out,
        input  write_register_address_in,
        input  write_data_in,
        input  read_valid_in,
        input  read_register_address_in,
        output read_data_out,
        output read_valid_out,
        input  clear_start_in,
        output busy_out
    );

    modport master (
        output write_valid_in,
        input  write_ready_out,
        output write_register_address_in,
        output write_data_in,
        output read_valid_in,
        output read_register_address_in,
        input  read_data_out,
        input  read_valid_out,
        output clear_start_in,
        input  busy_out
    );

endinterface

// File: rtl/register_file_clear_sequencer.sv
// -----------------------------------------------------------------------------
// register_file_clear_sequencer
// Purpose : Two-state FSM that sweeps zeros through the whole register array,
//           one address per cycle from 0 up to NUMBER_OF_REGISTERS-1.
// Ports   : clock_in                - clock
//           reset_n_in              - synchronous active-low reset; forces a
//                                     fresh sweep starting at address 0
//           clear_start_in          - start a sweep (ignored while sweeping)
//           busy_out                - sweep in progress
//           clear_write_enable_out  - write zero this cycle
//           clear_address_out       - address being zeroed this cycle
// -----------------------------------------------------------------------------
module register_file_clear_sequencer
    import register_file_pkg::*;
#(
    parameter int NUMBER_OF_REGISTERS = DEFAULT_NUMBER_OF_REGISTERS,
    localparam int ADDR_WIDTH         = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  clear_start_in,
    output logic                  busy_out,
    output logic                  clear_write_enable_out,
    output logic [ADDR_WIDTH-1:0] clear_address_out
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDRESS = ADDR_WIDTH'(NUMBER_OF_REGISTERS - 1);

    clear_state_e          state_q;
    logic [ADDR_WIDTH-1:0] pointer_q;

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state_q   <= CLEAR;
            pointer_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_start_in) begin
                        state_q   <= CLEAR;
                        pointer_q <= '0;
                    end
                end
                CLEAR: begin
                    // clear_start_in is deliberately not looked at here: a
                    // running sweep is never restarted or extended.
                    if (pointer_q == LAST_ADDRESS) begin
                        state_q <= IDLE;  // pointer parks at the last address
                    end else begin
                        pointer_q <= pointer_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    // Every busy cycle zeroes exactly one register, so the write enable is
    // simply the state decode.
    assign busy_out               = (state_q == CLEAR);
    assign clear_write_enable_out = (state_q == CLEAR);
    assign clear_address_out      = pointer_q;

endmodule

// File: rtl/multiport_register_file.sv
// -----------------------------------------------------------------------------
// multiport_register_file
// Purpose : Register array with one write port shared between user writes and
//           the zero sweep, plus NUMBER_OF_READ_PORTS registered read ports.
//           Reads are write-first against a same-cycle accepted write, and any
//           read sampled while the array is being (or about to be) cleared
//           returns zero.
// Ports   : clock_in   - clock
//           reset_n_in - synchronous active-low reset (array contents are not
//                        reset; a zero sweep follows release instead)
//           bus        - multiport_register_file_if.slave (write / read /
//                        clear handshakes)
// -----------------------------------------------------------------------------
module multiport_register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH           = DEFAULT_DATA_WIDTH,
    parameter int NUMBER_OF_REGISTERS  = DEFAULT_NUMBER_OF_REGISTERS,
    parameter int NUMBER_OF_READ_PORTS = DEFAULT_NUMBER_OF_READ_PORTS
) (
    input  logic                       clock_in,
    input  logic                       reset_n_in,
    multiport_register_file_if.slave   bus
);

    localparam int ADDR_WIDTH = $clog2(NUMBER_OF_REGISTERS);

    logic                  busy;
    logic                  clear_write_enable;
    logic [ADDR_WIDTH-1:0] clear_address;

    register_file_clear_sequencer #(
        .NUMBER_OF_REGISTERS (NUMBER_OF_REGISTERS)
    ) u_clear_sequencer (
        .clock_in               (clock_in),
        .reset_n_in             (reset_n_in),
        .clear_start_in         (bus.clear_start_in),
        .busy_out               (busy),
        .clear_write_enable_out (clear_write_enable),
        .clear_address_out      (clear_address)
    );

    assign bus.busy_out = busy;

    // Ready drops combinationally with clear_start_in so a write cannot land
    // in the same cycle the sweep is launched.
    logic write_ready;
    logic write_accept;
    assign write_ready         = !busy && !bus.clear_start_in;
    assign write_accept        = bus.write_valid_in && write_ready;
    assign bus.write_ready_out = write_ready;

    // Single write port: the sweep and user writes are mutually exclusive
    // because write_ready is low whenever the sweep runs.
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_write_address;
    logic [DATA_WIDTH-1:0] mem_write_data;

    assign mem_write_enable  = clear_write_enable || write_accept;
    assign mem_write_address = clear_write_enable ? clear_address : bus.write_register_address_in;
    assign mem_write_data    = clear_write_enable ? '0 : bus.write_data_in;

    logic [DATA_WIDTH-1:0] mem_q [NUMBER_OF_REGISTERS];

    always_ff @(posedge clock_in) begin
        if (mem_write_enable) begin
            mem_q[mem_write_address] <= mem_write_data;
        end
    end

    // A read must return zero when the sweep is running or being launched;
    // both cases are exactly the cases where write_ready is low.
    logic read_forces_zero;
    assign read_forces_zero = !write_ready;

    logic read_valid_q;

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            read_valid_q <= 1'b0;
        end else begin
            read_valid_q <= bus.read_valid_in;
        end
    end

    assign bus.read_valid_out = read_valid_q;

    for (genvar gi = 0; gi < NUMBER_OF_READ_PORTS; gi++) begin : g_read_port
        logic [ADDR_WIDTH-1:0] read_address;
        logic [DATA_WIDTH-1:0] read_data_d;
        logic [DATA_WIDTH-1:0] read_data_q;

        assign read_address = bus.read_register_address_in[gi*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            read_data_d = mem_q[read_address];
            if (read_forces_zero) begin
                read_data_d = '0;
            end else if (write_accept && (bus.write_register_address_in == read_address)) begin
                read_data_d = bus.write_data_in;  // write-first bypass
            end
        end

        // Output register holds its value between read requests.
        always_ff @(posedge clock_in) begin
            if (!reset_n_in) begin
                read_data_q <= '0;
            end else if (bus.read_valid_in) begin
                read_data_q <= read_data_d;
            end
        end

        assign bus.read_data_out[gi*DATA_WIDTH +: DATA_WIDTH] = read_data_q;
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// -----------------------------------------------------------------------------
// tb_multiport_register_file
// Directed stimulus for the multiport register file (default sizing: 8-bit
// data, 256 registers, 2 read ports). Expected read responses are queued when
// each read is issued; a negedge monitor pops and compares them whenever
// read_valid_out is high. Sweep length, ready and reset behaviour are checked
// directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_multiport_register_file;
    import register_file_pkg::*;

    localparam int DW = 8;
    localparam int NR = 256;
    localparam int NP = 2;
    localparam int AW = 8;

    logic clk;
    logic rst_n;

    multiport_register_file_if #(
        .DATA_WIDTH           (DW),
        .NUMBER_OF_REGISTERS  (NR),
        .NUMBER_OF_READ_PORTS (NP)
    ) rf_if ();

    multiport_register_file #(
        .DATA_WIDTH           (DW),
        .NUMBER_OF_REGISTERS  (NR),
        .NUMBER_OF_READ_PORTS (NP)
    ) dut (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .bus        (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [NP*DW-1:0] exp_q [$];
    logic [NP*DW-1:0] exp_v;

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (rf_if.read_valid_out === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL read_unexpected: got data=%h valid=1 required no read", rf_if.read_data_out);
            end else begin
                exp_v = exp_q.pop_front();
                if (rf_if.read_data_out !== exp_v) begin
                    bad++;
                    $display("FAIL read_data: got %h required %h", rf_if.read_data_out, exp_v);
                end else begin
                    $display("read data=%h", rf_if.read_data_out);
                end
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic idle_inputs();
        rf_if.write_valid_in            = 1'b0;
        rf_if.write_register_address_in = '0;
        rf_if.write_data_in             = '0;
        rf_if.read_valid_in             = 1'b0;
        rf_if.read_register_address_in  = '0;
        rf_if.clear_start_in            = 1'b0;
    endtask

    // One cycle of stimulus: optional write, optional read with its expected
    // response {port1, port0}.
    task automatic issue(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input bit rv, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                         input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        rf_if.write_valid_in            = wv;
        rf_if.write_register_address_in = wa;
        rf_if.write_data_in             = wd;
        rf_if.read_valid_in             = rv;
        rf_if.read_register_address_in  = {ra1, ra0};
        if (rv) exp_q.push_back({e1, e0});
        tick();
        idle_inputs();
    endtask

    // Counts busy cycles from the current sample point until IDLE, optionally
    // re-pulsing clear_start_in at count repulse_at and reading every cycle.
    task automatic count_busy(input int repulse_at, input bit do_reads,
                              output int n, output bit ready_seen);
        n = 0;
        ready_seen = 1'b0;
        while (rf_if.busy_out === 1'b1 && n < 1000) begin
            if (rf_if.write_ready_out !== 1'b0) ready_seen = 1'b1;
            rf_if.clear_start_in           = (n == repulse_at);
            rf_if.read_valid_in            = do_reads;
            rf_if.read_register_address_in = {AW'(n * 3), AW'(n)};
            if (do_reads) exp_q.push_back('0);
            n++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic fill_pattern();
        for (int a = 0; a < NR; a++) begin
            issue(1'b1, AW'(a), DW'(a ^ 8'hFF), 1'b0, '0, '0, '0, '0);
        end
    endtask

    task automatic read_all_zero();
        for (int a = 0; a < NR / 2; a++) begin
            issue(1'b0, '0, '0, 1'b1, AW'(a), AW'(a + NR / 2), 8'h00, 8'h00);
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    int n;
    bit ready_seen;

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Reset for two edges, then expect a full 256-cycle sweep.
        tick();
        tick();
        check("reset_read_valid", 32'(rf_if.read_valid_out), 32'h0);
        check("reset_read_data", 32'(rf_if.read_data_out), 32'h0);
        check("reset_busy", 32'(rf_if.busy_out), 32'h1);
        rst_n = 1'b1;
        count_busy(-1, 1'b1, n, ready_seen);
        check("power_up_sweep_len", 32'(n), 32'd256);
        check("ready_low_in_sweep", 32'(ready_seen), 32'h0);
        check("ready_high_idle", 32'(rf_if.write_ready_out), 32'h1);

        // Write then read two ports; then the output holds.
        issue(1'b1, 8'd7, 8'hA5, 1'b0, '0, '0, '0, '0);
        issue(1'b0, '0, '0, 1'b1, 8'd7, 8'd8, 8'hA5, 8'h00);
        tick();
        check("read_valid_drops", 32'(rf_if.read_valid_out), 32'h0);
        check("read_data_holds", 32'(rf_if.read_data_out), 32'h00A5);

        // Write-first bypass, both ports same address, and mixed addresses.
        issue(1'b1, 8'd20, 8'h3C, 1'b1, 8'd20, 8'd20, 8'h3C, 8'h3C);
        issue(1'b1, 8'd30, 8'h5E, 1'b1, 8'd30, 8'd7, 8'h5E, 8'hA5);
        issue(1'b0, '0, '0, 1'b1, 8'd20, 8'd30, 8'h3C, 8'h5E);

        // Fill with addr^0xFF and spot-check.
        fill_pattern();
        issue(1'b0, '0, '0, 1'b1, 8'd0, 8'd255, 8'hFF, 8'h00);
        issue(1'b0, '0, '0, 1'b1, 8'h5A, 8'h13, 8'hA5, 8'hEC);

        // Launch a sweep with a read in the launch cycle, re-pulse at cycle 10.
        rf_if.clear_start_in           = 1'b1;
        rf_if.read_valid_in            = 1'b1;
        rf_if.read_register_address_in = {8'h10, 8'h07};
        exp_q.push_back('0);
        #1;
        check("ready_low_on_clear_start", 32'(rf_if.write_ready_out), 32'h0);
        tick();
        idle_inputs();
        count_busy(9, 1'b1, n, ready_seen);
        check("clear_sweep_len", 32'(n), 32'd256);
        check("ready_low_in_clear", 32'(ready_seen), 32'h0);
        read_all_zero();

        // Write colliding with clear_start is dropped.
        issue(1'b1, 8'd3, 8'h77, 1'b0, '0, '0, '0, '0);
        issue(1'b0, '0, '0, 1'b1, 8'd3, 8'd3, 8'h77, 8'h77);
        rf_if.clear_start_in            = 1'b1;
        rf_if.write_valid_in            = 1'b1;
        rf_if.write_register_address_in = 8'd3;
        rf_if.write_data_in             = 8'h11;
        #1;
        check("ready_low_write_collide", 32'(rf_if.write_ready_out), 32'h0);
        tick();
        idle_inputs();
        count_busy(-1, 1'b0, n, ready_seen);
        check("collide_sweep_len", 32'(n), 32'd256);
        issue(1'b0, '0, '0, 1'b1, 8'd3, 8'd3, 8'h00, 8'h00);

        // Reset at sweep cycle 100 with a read in the reset cycle.
        fill_pattern();
        rf_if.clear_start_in = 1'b1;
        tick();
        idle_inputs();
        for (int c = 0; c < 100; c++) tick();
        check("busy_before_mid_reset", 32'(rf_if.busy_out), 32'h1);
        rst_n                          = 1'b0;
        rf_if.read_valid_in            = 1'b1;
        rf_if.read_register_address_in = {8'd6, 8'd5};
        tick();
        rf_if.read_valid_in = 1'b0;
        tick();
        check("mid_reset_read_valid", 32'(rf_if.read_valid_out), 32'h0);
        rst_n = 1'b1;
        count_busy(-1, 1'b0, n, ready_seen);
        check("restart_sweep_len", 32'(n), 32'd256);
        read_all_zero();

        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
